// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXEC/MEM/WB, issues memory and
// ALU handshakes, counts retired instructions and traps stalled handshakes into FAULT.
module stage_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Run,
  input  logic        ImemAck,
  input  logic        DmemAck,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        MulDiv,
  input  logic        AluDone,
  input  logic        BranchTaken,
  output logic        ImemReq,
  output logic        IrWrite,
  output logic        DmemReq,
  output logic        DmemWe,
  output logic        AluStart,
  output logic        RegFileWe,
  output logic        PcWrite,
  output logic        PcSel,
  output logic [2:0]  State,
  output logic        Fault,
  output logic [31:0] RetireCount
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6,
    S_RSVD   = 3'd7
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_n;
  logic [7:0]  wait_q, wait_n;
  logic        exec_first_q, exec_first_n;
  logic        redirect_q, redirect_n;
  logic [31:0] retire_q, retire_n;
  logic        retire;
  logic        imem_req, ir_wr, dmem_req, dmem_we, alu_start, rf_we;

  always_comb begin
    state_n      = state_q;
    wait_n       = wait_q;
    exec_first_n = 1'b0;
    redirect_n   = redirect_q;
    retire       = 1'b0;
    imem_req     = 1'b0;
    ir_wr        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    alu_start    = 1'b0;
    rf_we        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Run) begin
          state_n = S_FETCH;
          wait_n  = 8'd0;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        ir_wr    = ImemAck;
        if (ImemAck)                state_n = S_DECODE;
        else if (wait_q == TMO_LAST) state_n = S_FAULT;
        else                        wait_n  = wait_q + 8'd1;
      end
      S_DECODE: begin
        state_n      = S_EXEC;
        exec_first_n = 1'b1;
        wait_n       = 8'd0;
      end
      S_EXEC: begin
        // AluDone is only trusted from the cycle after the start pulse
        if (MulDiv && exec_first_q) begin
          alu_start = 1'b1;
        end else if (MulDiv && !AluDone) begin
          if (wait_q == TMO_LAST) state_n = S_FAULT;
          else                    wait_n  = wait_q + 8'd1;
        end else begin
          redirect_n = Jump | (Branch & BranchTaken);
          if (MemRead | MemWrite) begin
            state_n = S_MEM;
            wait_n  = 8'd0;
          end else if (RegWrite) begin
            state_n = S_WB;
          end else begin
            retire = 1'b1;
          end
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = MemWrite;
        if (DmemAck) begin
          if (MemRead) state_n = S_WB;
          else         retire  = 1'b1;
        end else if (wait_q == TMO_LAST) begin
          state_n = S_FAULT;
        end else begin
          wait_n = wait_q + 8'd1;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      S_FAULT: state_n = S_FAULT;
      default: state_n = S_IDLE;
    endcase
    if (retire) begin
      state_n = Run ? S_FETCH : S_IDLE;
      wait_n  = 8'd0;
    end
  end

  assign retire_n = retire_q + {31'd0, retire & ~rst};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wait_q       <= 8'd0;
      exec_first_q <= 1'b0;
      redirect_q   <= 1'b0;
      retire_q     <= 32'd0;
    end else begin
      state_q      <= state_n;
      wait_q       <= wait_n;
      exec_first_q <= exec_first_n;
      redirect_q   <= redirect_n;
      retire_q     <= retire_n;
    end
  end

  // Pulses are suppressed while reset is asserted; levels fall after the reset edge
  assign ImemReq     = imem_req;
  assign DmemReq     = dmem_req;
  assign DmemWe      = dmem_we;
  assign IrWrite     = ir_wr & ~rst;
  assign AluStart    = alu_start & ~rst;
  assign RegFileWe   = rf_we & ~rst;
  assign PcWrite     = retire & ~rst;
  assign PcSel       = redirect_n;
  assign State       = state_q;
  assign Fault       = (state_q == S_FAULT);
  assign RetireCount = retire_q;

endmodule
